// File: rtl/cic_interp_sdm_pkg.sv
// Shared widths, types and saturation helper for the CIC interpolator and its
// second-order 1-bit sigma-delta back end.
package cic_interp_sdm_pkg;

  localparam int     IN_W     = 16;
  localparam int     ACC_W    = 48;
  localparam int     SDM_W    = 22;
  localparam int     N_STAGES = 3;
  localparam longint FS       = longint'(1) <<< (IN_W - 1);

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [IN_W-1:0]  pcm_t;

  // Clamp a signed value to the range of a w-bit two's complement word.
  function automatic longint sat(input longint v, input int w);
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (w - 1)) - longint'(1);
    lo = -hi - longint'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/cic_interp_sdm_sdm2.sv
// Second-order 1-bit sigma-delta modulator; one output bit per clk, one cycle
// from pcm_out to out_bit. Integrators saturate instead of wrapping.
module cic_interp_sdm_sdm2
  import cic_interp_sdm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [IN_W-1:0] pcm_out,
  output logic                   out_bit
);

  typedef logic signed [SDM_W-1:0] sdm_t;

  sdm_t   s1;
  sdm_t   s2;
  longint fb;
  longint s1_next;
  longint s2_next;

  // The second integrator takes the freshly updated first-stage value so the
  // noise transfer is the plain (1 - z^-1)^2 shape.
  always_comb begin
    fb      = out_bit ? FS : -FS;
    s1_next = sat(longint'(s1) + longint'(pcm_out) - fb, SDM_W);
    s2_next = sat(longint'(s2) + s1_next - fb, SDM_W);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= '0;
      s2      <= '0;
      out_bit <= 1'b0;
    end else begin
      s1      <= sdm_t'(s1_next);
      s2      <= sdm_t'(s2_next);
      out_bit <= (s2_next >= 0);
    end
  end

endmodule

// File: rtl/cic_interp_sdm.sv
// 3-stage CIC interpolator (runtime ratio R) feeding a 1-bit sigma-delta modulator.
// Takes one PCM sample per R clocks when in_ready; a missing sample becomes zero and sets underrun.
module cic_interp_sdm
  import cic_interp_sdm_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [15:0]            interp_ratio,
  input  logic [5:0]             gain_shift,
  input  logic signed [IN_W-1:0] in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic signed [IN_W-1:0] pcm_out,
  output logic                   out_bit,
  output logic                   underrun
);

  logic [15:0] count;
  logic [15:0] r_act;
  logic        tick;
  logic        stuff_q;
  acc_t        x;
  acc_t        c1;
  acc_t        c2;
  acc_t        c3;
  acc_t        c3_q;
  acc_t        u;
  acc_t        cd [N_STAGES];
  acc_t        ig [N_STAGES];
  pcm_t        pcm_next;

  assign tick     = (count == r_act - 16'd1);
  assign in_ready = tick && !rst;
  assign u        = stuff_q ? c3_q : '0;

  always_comb begin
    x        = in_valid ? acc_t'(in_data) : '0;
    c1       = x - cd[0];
    c2       = c1 - cd[1];
    c3       = c2 - cd[2];
    pcm_next = pcm_t'(sat(longint'(ig[N_STAGES-1] >>> gain_shift), IN_W));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= '0;
      r_act    <= 16'd2;
      cd       <= '{default: '0};
      c3_q     <= '0;
      stuff_q  <= 1'b0;
      ig       <= '{default: '0};
      pcm_out  <= '0;
      underrun <= 1'b0;
    end else begin
      stuff_q <= tick;
      if (tick) begin
        count <= '0;
        // New ratio only ever lands on a period boundary.
        r_act <= (interp_ratio < 16'd2) ? 16'd2 : interp_ratio;
        cd[0] <= x;
        cd[1] <= c1;
        cd[2] <= c2;
        c3_q  <= c3;
        if (!in_valid) underrun <= 1'b1;
      end else begin
        count <= count + 16'd1;
      end
      // Integrators wrap modulo 2^ACC_W; the comb differences cancel the wrap.
      ig[0] <= ig[0] + u;
      for (int k = 1; k < N_STAGES; k++) ig[k] <= ig[k] + ig[k-1];
      pcm_out <= pcm_next;
    end
  end

  cic_interp_sdm_sdm2 u_sdm2 (
    .clk     (clk),
    .rst     (rst),
    .pcm_out (pcm_out),
    .out_bit (out_bit)
  );

endmodule

// File: tb/tb_cic_interp_sdm.sv
// Bench for cic_interp_sdm: a convolution model of the interpolator (three
// cascaded R-wide boxcars) plus an arithmetic SDM model, checked every cycle.
module tb_cic_interp_sdm;
  import cic_interp_sdm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] interp_ratio;
  logic [5:0]  gain_shift;
  pcm_t        in_data;
  logic        in_valid;
  logic        in_ready;
  pcm_t        pcm_out;
  logic        out_bit;
  logic        underrun;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int     m_until;
  int     m_t;
  int     s_e[$];
  longint s_x[$];
  longint h[64];
  int     h_len;
  longint m_s1, m_s2, exp_pcm;
  logic   m_ob, m_und;

  always #5 clk = ~clk;

  cic_interp_sdm dut (
    .clk          (clk),
    .rst          (rst),
    .interp_ratio (interp_ratio),
    .gain_shift   (gain_shift),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pcm_out      (pcm_out),
    .out_bit      (out_bit),
    .underrun     (underrun)
  );

  function automatic longint clampw(longint v, int w);
    longint hi;
    hi = (longint'(1) << (w - 1)) - 1;
    if (v > hi) return hi;
    if (v < -hi - 1) return -hi - 1;
    return v;
  endfunction

  // Impulse response of the interpolator: three length-R boxcars convolved.
  function automatic void build_h(int r);
    longint a[64];
    longint b[64];
    int     len;
    for (int i = 0; i < 64; i++) a[i] = (i < r) ? 1 : 0;
    len = r;
    for (int p = 0; p < 2; p++) begin
      for (int n = 0; n < 64; n++) begin
        b[n] = 0;
        for (int j = 0; j < r; j++) if (n - j >= 0) b[n] += a[n-j];
      end
      a = b;
      len += r - 1;
    end
    h = a;
    h_len = len;
  endfunction

  function automatic longint conv_at(int n);
    longint acc;
    int     k;
    acc = 0;
    for (int i = 0; i < s_e.size(); i++) begin
      k = n - s_e[i];
      if (k >= 0 && k < h_len) acc += h[k] * s_x[i];
    end
    return acc;
  endfunction

  function automatic void model_reset();
    m_until = 2;
    m_t     = 0;
    s_e.delete();
    s_x.delete();
    m_s1 = 0; m_s2 = 0; m_ob = 1'b0; m_und = 1'b0; exp_pcm = 0;
  endfunction

  // One clock: advance DUT and model together, return #1 after the edge.
  task automatic step();
    logic   tk, v;
    longint xin, fb, s1n, s2n;
    int     ratio, sh;
    tk    = (m_until == 1) && !rst;
    v     = in_valid;
    xin   = v ? longint'(in_data) : 0;
    ratio = int'(interp_ratio);
    sh    = int'(gain_shift);
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      m_t++;
      if (tk) begin
        s_e.push_back(m_t);
        s_x.push_back(xin);
        if (!v) m_und = 1'b1;
        m_until = (ratio < 2) ? 2 : ratio;
      end else begin
        m_until--;
      end
      fb   = m_ob ? 32768 : -32768;
      s1n  = clampw(m_s1 + exp_pcm - fb, 22);
      s2n  = clampw(m_s2 + s1n - fb, 22);
      m_s1 = s1n;
      m_s2 = s2n;
      m_ob = (s2n >= 0);
      exp_pcm = clampw(conv_at(m_t - 4) >>> sh, 16);
    end
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    interp_ratio = 16'd4; gain_shift = 6'd2; in_valid = 1'b0; build_h(4);
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      in_valid = (c >= 6);
      in_data  = pcm_t'(int'($urandom_range(0, 8000)) - 4000);
      step();
      checks++;
      if (longint'(pcm_out) !== exp_pcm) begin
        errors++; $display("FAIL reset_pre_pcm: got %0d expected %0d", pcm_out, exp_pcm);
      end
    end
    checks++;
    if (underrun !== 1'b1) begin
      errors++; $display("FAIL reset_pre_underrun: got %b expected 1", underrun);
    end
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if (pcm_out !== '0 || out_bit !== 1'b0 || in_ready !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got pcm=%0d bit=%b rdy=%b und=%b expected 0 0 0 0",
               pcm_out, out_bit, in_ready, underrun);
    end
    rst = 1'b0;
    step();
    checks++;
    if (pcm_out !== '0 || underrun !== 1'b0 || in_ready !== (m_until == 1) || out_bit !== m_ob) begin
      errors++;
      $display("FAIL reset_release: got pcm=%0d und=%b rdy=%b bit=%b expected 0 0 %b %b",
               pcm_out, underrun, in_ready, out_bit, (m_until == 1), m_ob);
    end
  endtask

  task automatic test_impulse();
    int  tbl[10];
    int  t_acc, k;
    logic take;
    longint lit;
    tbl = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};
    t_acc = -100;
    interp_ratio = 16'd4; gain_shift = 6'd0; in_valid = 1'b1; in_data = '0; build_h(4);
    apply_reset();
    for (int c = 0; c < 24; c++) begin
      take    = (m_until == 1) && (t_acc < 0);
      in_data = take ? pcm_t'(1) : pcm_t'(0);
      checks++;
      if (in_ready !== (m_until == 1)) begin
        errors++; $display("FAIL impulse_ready: got %b expected %b", in_ready, (m_until == 1));
      end
      step();
      if (take) t_acc = m_t;
      k   = m_t - t_acc - 4;
      lit = (t_acc >= 0 && k >= 0 && k < 10) ? longint'(tbl[k]) : 0;
      checks++;
      if (longint'(pcm_out) !== lit || exp_pcm !== lit) begin
        errors++; $display("FAIL impulse_pcm: got %0d expected %0d (edge %0d)", pcm_out, lit, m_t);
      end
    end
  endtask

  task automatic test_dc();
    interp_ratio = 16'd4; gain_shift = 6'd4; in_valid = 1'b1; in_data = 16'sd1000; build_h(4);
    apply_reset();
    for (int c = 0; c < 60; c++) begin
      step();
      checks++;
      if (longint'(pcm_out) !== exp_pcm) begin
        errors++; $display("FAIL dc_model: got %0d expected %0d", pcm_out, exp_pcm);
      end
      if (m_t >= 17) begin
        checks++;
        if (pcm_out !== 16'sd1000) begin
          errors++; $display("FAIL dc_settled: got %0d expected 1000", pcm_out);
        end
      end
    end
  endtask

  task automatic test_saturation();
    logic hit;
    int   seen[$];
    hit = 1'b0;
    interp_ratio = 16'd16; gain_shift = 6'd0; in_valid = 1'b1; in_data = 16'sd30000; build_h(16);
    apply_reset();
    for (int c = 0; c < 120; c++) begin
      step();
      checks++;
      if (longint'(pcm_out) !== exp_pcm) begin
        errors++; $display("FAIL sat_model: got %0d expected %0d", pcm_out, exp_pcm);
      end
      if (hit) begin
        checks++;
        if (pcm_out !== 16'sd32767) begin
          errors++; $display("FAIL sat_wrap: got %0d expected 32767", pcm_out);
        end
      end
      if (pcm_out == 16'sd32767) hit = 1'b1;
    end
    checks++;
    if (pcm_out !== 16'sd32767) begin
      errors++; $display("FAIL sat_clamp: got %0d expected 32767", pcm_out);
    end
    for (int c = 0; c < 32 && m_until != 5; c++) step();
    interp_ratio = 16'd8;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (in_ready) seen.push_back(c);
      checks++;
      if (in_ready !== (m_until == 1)) begin
        errors++; $display("FAIL ratio_ready: got %b expected %b", in_ready, (m_until == 1));
      end
    end
    checks++;
    if (seen.size() != 3 || seen[0] != 4 || seen[1] != 12 || seen[2] != 20) begin
      errors++; $display("FAIL ratio_change: got %0d ticks expected 3 at cycles 4,12,20", seen.size());
    end
  endtask

  task automatic test_sdm_density();
    int ones;
    interp_ratio = 16'd4; gain_shift = 6'd0; in_valid = 1'b0; in_data = '0; build_h(4);
    apply_reset();
    repeat (20) step();
    ones = 0;
    for (int c = 0; c < 1024; c++) begin
      step();
      if (out_bit) ones++;
      checks++;
      if (out_bit !== m_ob || longint'(pcm_out) !== exp_pcm) begin
        errors++; $display("FAIL sdm_zero_bit: got %b/%0d expected %b/%0d", out_bit, pcm_out, m_ob, exp_pcm);
      end
    end
    checks++;
    if (ones < 510 || ones > 514) begin
      errors++; $display("FAIL sdm_zero_density: got %0d ones expected 512+/-2", ones);
    end
    gain_shift = 6'd4; in_valid = 1'b1; in_data = 16'sd16384;
    apply_reset();
    repeat (60) step();
    ones = 0;
    for (int c = 0; c < 1024; c++) begin
      step();
      if (out_bit) ones++;
      checks++;
      if (out_bit !== m_ob || longint'(pcm_out) !== exp_pcm) begin
        errors++; $display("FAIL sdm_half_bit: got %b/%0d expected %b/%0d", out_bit, pcm_out, m_ob, exp_pcm);
      end
    end
    checks++;
    if (ones < 764 || ones > 772) begin
      errors++; $display("FAIL sdm_half_density: got %0d ones expected 768+/-4", ones);
    end
  endtask

  task automatic test_random();
    int rl[4];
    rl = '{2, 3, 5, 8};
    for (int r = 0; r < 4; r++) begin
      interp_ratio = 16'(rl[r]);
      gain_shift   = 6'($urandom_range(0, 6));
      in_valid     = 1'b1;
      build_h(rl[r]);
      apply_reset();
      for (int c = 0; c < 250; c++) begin
        in_valid = ($urandom_range(0, 9) != 0);
        in_data  = pcm_t'(int'($urandom_range(0, 8000)) - 4000);
        step();
        checks++;
        if (longint'(pcm_out) !== exp_pcm || out_bit !== m_ob ||
            in_ready !== (m_until == 1) || underrun !== m_und) begin
          errors++;
          $display("FAIL random_r%0d: got pcm=%0d bit=%b rdy=%b und=%b expected %0d %b %b %b",
                   rl[r], pcm_out, out_bit, in_ready, underrun, exp_pcm, m_ob, (m_until == 1), m_und);
        end
      end
    end
  endtask

  task automatic test_underrun_ratio();
    int nrdy, ticks;
    for (int r = 0; r < 2; r++) begin
      interp_ratio = 16'(r); gain_shift = 6'd2; in_valid = 1'b1; build_h(2);
      apply_reset();
      nrdy = 0; ticks = 0;
      for (int c = 0; c < 40; c++) begin
        in_data  = pcm_t'(int'($urandom_range(0, 8000)) - 4000);
        in_valid = !((m_until == 1) && ticks == 2);
        if (m_until == 1) ticks++;
        if (in_ready) nrdy++;
        step();
        checks++;
        if (longint'(pcm_out) !== exp_pcm || in_ready !== (m_until == 1) || underrun !== m_und) begin
          errors++;
          $display("FAIL underrun_r%0d: got pcm=%0d rdy=%b und=%b expected %0d %b %b",
                   r, pcm_out, in_ready, underrun, exp_pcm, (m_until == 1), m_und);
        end
      end
      checks++;
      if (nrdy != 20 || underrun !== 1'b1) begin
        errors++; $display("FAIL ratio_min_r%0d: got rdy=%0d und=%b expected 20 1", r, nrdy, underrun);
      end
    end
    apply_reset();
    checks++;
    if (underrun !== 1'b0) begin
      errors++; $display("FAIL underrun_clear: got %b expected 0", underrun);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; interp_ratio = 16'd4; gain_shift = '0;
    build_h(4);
    model_reset();
    test_reset();
    test_impulse();
    test_dc();
    test_saturation();
    test_sdm_density();
    test_random();
    test_underrun_ratio();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
